// File: rtl/line_ring_pkg.sv
// rtl/line_ring_pkg.sv - shared sizing, legality and index helpers for line_ring_buffer
package line_ring_pkg;

    localparam int MIN_LINES = 3;
    localparam int MAX_LINES = 16;

    typedef enum logic [1:0] {
        ADV_NONE = 2'd0,
        ADV_ONE  = 2'd1,
        ADV_TWO  = 2'd2
    } rd_adv_e;

    function automatic int calc_cnt_w(input int line_count);
        return $clog2(line_count);
    endfunction

    function automatic bit line_count_legal(input int line_count);
        return (line_count >= MIN_LINES) && (line_count <= MAX_LINES);
    endfunction

    // Ring index step; step never exceeds two so a single modulo suffices.
    function automatic int next_index(input int idx, input int step, input int line_count);
        return (idx + step) % line_count;
    endfunction

endpackage

// File: rtl/line_ram.sv
// rtl/line_ram.sv - one line of pixel storage: port A write-or-read, port B read-only
module line_ram
    import line_ring_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_en,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_en,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (a_en && a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    // Output registers only move on a read, so the last tap value holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_en && !a_we) begin
                a_rdata <= mem[a_addr];
            end
            if (b_en) begin
                b_rdata <= mem[b_addr];
            end
        end
    end

endmodule

// File: rtl/line_ring_buffer.sv
// rtl/line_ring_buffer.sv - ring of line RAMs with 2x2 tap reads; LINE_RING_ERR_FLAGS_EN adds sticky error flags
module line_ring_buffer
    import line_ring_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_COUNT = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_en,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic                                wr_advance,
    input  logic                                rd_en,
    input  logic [ADDR_WIDTH-1:0]               rd_addr,
    input  logic                                rd_advance1,
    input  logic                                rd_advance2,
    output logic                                rd_valid,
    output logic [DATA_WIDTH-1:0]               rd_data00,
    output logic [DATA_WIDTH-1:0]               rd_data01,
    output logic [DATA_WIDTH-1:0]               rd_data10,
    output logic [DATA_WIDTH-1:0]               rd_data11,
    output logic [calc_cnt_w(LINE_COUNT)-1:0]   fill_count,
    output logic                                empty,
    output logic                                full
`ifdef LINE_RING_ERR_FLAGS_EN
    ,
    input  logic                                err_clr,
    output logic                                err_ovf,
    output logic                                err_unf
`endif
);

    localparam int CNT_W = calc_cnt_w(LINE_COUNT);
    localparam int IDX_W = CNT_W;
    localparam int SUM_W = CNT_W + 1;

    if (!line_count_legal(LINE_COUNT)) begin : g_bad_line_count
        $error("line_ring_buffer: LINE_COUNT must be within 3..16");
    end

    logic [IDX_W-1:0]      wr_line;
    logic [IDX_W-1:0]      rd_line;
    logic [IDX_W-1:0]      rd_line_p1;
    logic [IDX_W-1:0]      sel0_q;
    logic [IDX_W-1:0]      sel1_q;
    logic [CNT_W-1:0]      fill;
    rd_adv_e               rd_req;
    logic [1:0]            rd_acc;
    logic                  wr_acc;
    logic                  rd_ok;
    logic [SUM_W-1:0]      fill_ext;
    logic [SUM_W-1:0]      after_rd;
    logic [ADDR_WIDTH-1:0] rd_addr_p1;

    logic [LINE_COUNT-1:0] a_en;
    logic [LINE_COUNT-1:0] a_we;
    logic [DATA_WIDTH-1:0] a_rd [LINE_COUNT];
    logic [DATA_WIDTH-1:0] b_rd [LINE_COUNT];

    always_comb begin
        rd_req = ADV_NONE;
        if (rd_advance1) begin
            rd_req = ADV_ONE;
        end else if (rd_advance2) begin
            rd_req = ADV_TWO;
        end
        fill_ext = {1'b0, fill};
        rd_acc   = (fill_ext >= SUM_W'(rd_req)) ? rd_req : 2'd0;
        // Write acceptance sees the space freed by a same-cycle read advance.
        after_rd = fill_ext - SUM_W'(rd_acc);
        wr_acc   = wr_advance && (after_rd < SUM_W'(LINE_COUNT - 1));
        rd_ok    = rd_en && (fill_ext >= SUM_W'(2));
    end

    assign rd_line_p1 = IDX_W'(next_index(int'(rd_line), 1, LINE_COUNT));
    assign rd_addr_p1 = rd_addr + ADDR_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_line  <= '0;
            rd_line  <= '0;
            fill     <= '0;
            rd_valid <= 1'b0;
            sel0_q   <= '0;
            sel1_q   <= '0;
        end else begin
            fill     <= CNT_W'(after_rd + SUM_W'(wr_acc));
            rd_line  <= IDX_W'(next_index(int'(rd_line), int'(rd_acc), LINE_COUNT));
            rd_valid <= rd_ok;
            if (wr_acc) begin
                wr_line <= IDX_W'(next_index(int'(wr_line), 1, LINE_COUNT));
            end
            if (rd_ok) begin
                sel0_q <= rd_line;
                sel1_q <= rd_line_p1;
            end
        end
    end

    // The write line never coincides with a read line while a tap read is legal,
    // so port A of the write line can be handed to the writer unconditionally.
    for (genvar i = 0; i < LINE_COUNT; i++) begin : g_line
        localparam logic [IDX_W-1:0] IDX = IDX_W'(i);

        assign a_we[i] = wr_en && (wr_line == IDX);
        assign a_en[i] = a_we[i] || rd_ok;

        line_ram #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_line_ram (
            .clk    (clk),
            .rst_n  (rst_n),
            .a_en   (a_en[i]),
            .a_we   (a_we[i]),
            .a_addr (a_we[i] ? wr_addr : rd_addr),
            .a_wdata(wr_data),
            .a_rdata(a_rd[i]),
            .b_en   (rd_ok),
            .b_addr (rd_addr_p1),
            .b_rdata(b_rd[i])
        );
    end

    assign rd_data00  = a_rd[sel0_q];
    assign rd_data01  = b_rd[sel0_q];
    assign rd_data10  = a_rd[sel1_q];
    assign rd_data11  = b_rd[sel1_q];
    assign fill_count = fill;
    assign empty      = (fill == '0);
    assign full       = (fill == CNT_W'(LINE_COUNT - 1));

`ifdef LINE_RING_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (wr_advance && !wr_acc) begin
                err_ovf <= 1'b1;
            end else if (err_clr) begin
                err_ovf <= 1'b0;
            end
            if ((rd_req != ADV_NONE) && (rd_acc == 2'd0)) begin
                err_unf <= 1'b1;
            end else if (err_clr) begin
                err_unf <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: doc/line_ring_buffer.md
LINE_RING_BUFFER -- requirements
Module: line_ring_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning pixel word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning column address width; line length is 2**ADDR_WIDTH.
REQ-003 SHALL have parameter LINE_COUNT, default 4, meaning number of line RAMs; legal range 3..16.
REQ-004 SHALL have one clock and asynchronous active-low reset: clk (in, 1, rising-edge clock), then rst_n (in, 1, async active-low reset).
REQ-005 SHALL have write ports: wr_en (in, 1, write strobe), wr_addr (in, ADDR_WIDTH, column), wr_data (in, DATA_WIDTH, word) and wr_advance (in, 1, commit current write line).
REQ-006 SHALL have read ports: rd_en (in, 1, read strobe), rd_addr (in, ADDR_WIDTH, column), rd_advance1 (in, 1, consume one line) and rd_advance2 (in, 1, consume two lines).
REQ-007 SHALL have read outputs: rd_valid (out, 1), and rd_data00, rd_data01, rd_data10, rd_data11 (out, DATA_WIDTH each); the first index is line offset, the second is column offset.
REQ-008 SHALL have status outputs: fill_count (out, CNT_W = $clog2(LINE_COUNT), committed unconsumed lines), empty (out, 1) and full (out, 1).

Function
REQ-009 SHALL keep wr_line and rd_line indices in 0..LINE_COUNT-1, each incrementing modulo LINE_COUNT.
REQ-010 SHALL write wr_data to line wr_line at wr_addr when wr_en=1, regardless of full.
REQ-011 SHALL treat rd_advance1 as having priority over rd_advance2 when both are asserted.
REQ-012 SHALL accept a read advance of N lines only if fill_count>=N, adding N to rd_line; otherwise rd_line SHALL be unchanged.
REQ-013 SHALL accept wr_advance only if (fill_count - accepted_read_N) < LINE_COUNT-1; on acceptance wr_line SHALL increment.
REQ-014 SHALL update fill_count as fill_count + wr_accept - accepted_read_N in the same cycle, handling simultaneous read and write advances.
REQ-015 SHALL drive empty = (fill_count==0) and full = (fill_count==LINE_COUNT-1), both combinational from registered state.
REQ-016 SHALL perform a tap read when rd_en=1 and fill_count>=2: row 0 is line rd_line, row 1 is line (rd_line+1) mod LINE_COUNT, column 0 is rd_addr and column 1 is (rd_addr+1) mod 2**ADDR_WIDTH.
REQ-017 SHALL present tap read data one cycle after rd_en, with rd_valid=1 for that single cycle.
REQ-018 SHALL sample the line selection in the rd_en cycle, so a same-cycle read advance does not affect that read.
REQ-019 SHALL ignore rd_en when fill_count<2: rd_valid stays 0 and rd_data* hold their previous values.
REQ-020 SHALL never allow the write line to alias either read line while fill_count>=2; no write-blocking input exists.

Reset
REQ-021 SHALL, on rst_n=0 asynchronously, clear wr_line, rd_line and fill_count to 0, set empty=1 and full=0, and clear rd_valid and all rd_data* outputs to 0.
REQ-022 SHALL leave RAM contents unreset; reset mid-line SHALL discard all committed lines.

Configuration
REQ-023 SHALL compile, when LINE_RING_ERR_FLAGS_EN is defined, outputs err_ovf and err_unf (out, 1 each) plus input err_clr (in, 1).
REQ-024 SHALL set err_ovf sticky on a rejected wr_advance and err_unf sticky on a rejected read advance; both SHALL clear on err_clr or reset, with set winning over err_clr.
REQ-025 SHALL, without LINE_RING_ERR_FLAGS_EN, omit those ports, with rejected advances silently dropped.

Structure
REQ-026 SHALL place CNT_W derivation, the line-index increment-modulo function and LINE_COUNT legality checks in shared package line_ring_pkg.
REQ-027 SHALL instantiate LINE_COUNT copies of sub-module line_ram: single-clock dual-port, port A write-or-read, port B read-only, registered outputs with read enable and async reset.
REQ-028 SHALL register the output mux selection; no combinational path from rd_advance* to rd_data*.

Verification
REQ-029 SHALL cover fill: LINE_COUNT=4; write columns 0..255 of three lines with ramp values, asserting wr_advance after each -> fill_count 1,2,3, full=1 after the third; a fourth wr_advance is rejected (err_ovf=1 when enabled).
REQ-030 SHALL cover taps: two lines committed with line k, col c = k*16+c; rd_en with rd_addr=255 -> next cycle 00=255&0xFF, 01=col 0 of line 0, 10=line1 col255, 11=line1 col0, rd_valid=1.
REQ-031 SHALL cover the simultaneous case: fill_count=3 (full), wr_advance and rd_advance1 in the same cycle -> both accepted, fill_count stays 3, rd_line+1, wr_line+1.
REQ-032 SHALL cover read underflow: fill_count=1, rd_advance2 -> rejected, rd_line unchanged (err_unf=1 when enabled); rd_en -> rd_valid stays 0.
REQ-033 SHALL cover wrap: 10 commit/consume cycles with LINE_COUNT=3 -> indices wrap 2->0, and read data always matches the line written 2 commits earlier.
REQ-034 SHALL cover reset mid-operation: rst_n pulsed low with fill_count=2 -> fill_count=0, empty=1, rd_valid=0 and rd_data*=0 immediately without a clock edge.
